// File: rtl/ov7670_stream_tx.sv
// OV7670-style camera source: streams RGB565 pixels from a frame buffer as D/HREF/HSYNC/VSYNC on PCLK.
// Define OV7670_TX_PATTERN_EN to replace the frame-buffer path with a generated test pattern.
module ov7670_stream_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int H_SYNC   = 80,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_TOTAL  = 510,
    localparam int AW      = $clog2(H_ACTIVE*V_ACTIVE)
) (
    input  logic          PCLK,
    input  logic          RST,
    input  logic          EN,
    output logic          RD_EN,
    output logic [AW-1:0] RD_ADDR,
    input  logic [15:0]   RD_DATA,
    output logic [7:0]    D,
    output logic          HREF,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          FRAME_START,
    output logic          dbg_run
);

    localparam int HW = $clog2(2*H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(2*H_TOTAL-1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL-1);
    localparam int V_FIRST = V_SYNC + V_BACK;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rd_en_q, rd_en_d;
    logic            run_q, run_d;

    // Stage 1: flags decoded from the counters, one cycle behind them.
    logic            p1_href_q, p1_odd_q, p1_hs_q, p1_vs_q, p1_fs_q;
    logic            c_href, c_hs, c_vs, c_fs;

    // Stage 2: the registered outputs.
    logic [7:0]      d_q, d_d;
    logic            href_q, hs_q, vs_q, fs_q;

`ifdef OV7670_TX_PATTERN_EN
    logic [15:0]     pix_q, pix_d;
    logic [31:0]     pat_x, pat_line;
`else
    logic [7:0]      lo_q, lo_d;
`endif

    function automatic logic is_active(input logic [HW-1:0] h, input logic [VW-1:0] v);
        return (int'(v) >= V_FIRST) && (int'(v) < V_FIRST + V_ACTIVE) && (int'(h) < 2*H_ACTIVE);
    endfunction

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (EN) state_d = S_RUN;
            end
            S_RUN: begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    if (v_q == V_LAST) begin
                        v_d = '0;
                        if (!EN) state_d = S_IDLE;
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign run_d = (state_d == S_RUN);
    assign run_q = (state_q == S_RUN);

    // Read strobe and address are decoded from the next counter value so the
    // registered strobe lines up with the counter state it belongs to.
    always_comb begin
`ifdef OV7670_TX_PATTERN_EN
        rd_en_d = 1'b0;
`else
        rd_en_d = run_d && is_active(h_d, v_d) && !h_d[0];
`endif
        addr_d = addr_q;
        if (!run_d || (h_d == '0 && v_d == '0)) addr_d = '0;
        else if (rd_en_q)                        addr_d = addr_q + 1'b1;
    end

    always_comb begin
        c_href = run_q && is_active(h_q, v_q);
        c_vs   = run_q && (int'(v_q) < V_SYNC);
        c_hs   = run_q && (int'(h_q) >= 2*H_ACTIVE) && (int'(h_q) < 2*(H_ACTIVE + H_SYNC));
        c_fs   = run_q && (h_q == '0) && (v_q == '0);
    end

`ifdef OV7670_TX_PATTERN_EN
    always_comb begin
        pat_x    = 32'(int'(h_q) / 2);
        pat_line = 32'(int'(v_q) - V_FIRST);
        pix_d    = {pat_x[4:0], pat_x[5:0], pat_line[4:0]};
        d_d      = 8'h00;
        if (p1_href_q) d_d = p1_odd_q ? pix_q[7:0] : pix_q[15:8];
    end
`else
    // High byte goes straight from the read port; the low byte is parked for the odd slot.
    always_comb begin
        lo_d = lo_q;
        d_d  = 8'h00;
        if (p1_href_q) begin
            if (p1_odd_q) begin
                d_d = lo_q;
            end else begin
                d_d  = RD_DATA[15:8];
                lo_d = RD_DATA[7:0];
            end
        end
    end
`endif

    always_ff @(posedge PCLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            h_q       <= '0;
            v_q       <= '0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            p1_href_q <= 1'b0;
            p1_odd_q  <= 1'b0;
            p1_hs_q   <= 1'b0;
            p1_vs_q   <= 1'b0;
            p1_fs_q   <= 1'b0;
            d_q       <= 8'h00;
            href_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
`ifdef OV7670_TX_PATTERN_EN
            pix_q     <= 16'h0000;
`else
            lo_q      <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            v_q       <= v_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            p1_href_q <= c_href;
            p1_odd_q  <= h_q[0];
            p1_hs_q   <= c_hs;
            p1_vs_q   <= c_vs;
            p1_fs_q   <= c_fs;
            d_q       <= d_d;
            href_q    <= p1_href_q;
            hs_q      <= p1_hs_q;
            vs_q      <= p1_vs_q;
            fs_q      <= p1_fs_q;
`ifdef OV7670_TX_PATTERN_EN
            pix_q     <= pix_d;
`else
            lo_q      <= lo_d;
`endif
        end
    end

    assign RD_EN       = rd_en_q;
    assign RD_ADDR     = addr_q;
    assign D           = d_q;
    assign HREF        = href_q;
    assign HSYNC       = hs_q;
    assign VSYNC       = vs_q;
    assign FRAME_START = fs_q;
    assign dbg_run     = run_q;

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Bench for ov7670_stream_tx on a tiny frame (4x3 active, 6x6 total); frame-position model plus directed checks.
module tb_ov7670_stream_tx;

    localparam int HA = 4, HT = 6, HS = 1, VA = 3, VS = 1, VB = 1, VT = 6;
    localparam int AW = $clog2(HA*VA);
    localparam int LINE_SLOTS = 2*HT;
    localparam int FRAME_LEN  = LINE_SLOTS*VT;

    logic          PCLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          RD_EN;
    logic [AW-1:0] RD_ADDR;
    logic [15:0]   RD_DATA = 16'h0000;
    logic [7:0]    D;
    logic          HREF, HSYNC, VSYNC, FRAME_START, dbg_run;

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_on   = 1'b0;

    // Model: position of the transmitter inside its frame (-1 = idle), now and two cycles ago.
    int pos_m = -1;
    int h0_m  = -1;
    int h1_m  = -1;

    logic [7:0] exp_q[$];

    ov7670_stream_tx #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HS),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
    ) dut (
        .PCLK(PCLK), .RST(RST), .EN(EN),
        .RD_EN(RD_EN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
        .D(D), .HREF(HREF), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .FRAME_START(FRAME_START), .dbg_run(dbg_run)
    );

    // Clock / reset block
    always #5 PCLK = ~PCLK;

    // Frame buffer with one-cycle read latency
    always @(posedge PCLK) begin
        if (RD_EN) RD_DATA <= 16'(RD_ADDR) + 16'hA500;
    end

    always @(posedge PCLK) begin
        if (RST) begin
            pos_m <= -1;
            h0_m  <= -1;
            h1_m  <= -1;
        end else begin
            h0_m <= pos_m;
            h1_m <= h0_m;
            if (pos_m < 0 || pos_m == FRAME_LEN-1) pos_m <= EN ? 0 : -1;
            else                                   pos_m <= pos_m + 1;
        end
    end

    function automatic int line_of(input int p);
        return p / LINE_SLOTS;
    endfunction

    function automatic int slot_of(input int p);
        return p % LINE_SLOTS;
    endfunction

    function automatic bit m_active(input int p);
        if (p < 0) return 1'b0;
        return line_of(p) >= VS+VB && line_of(p) < VS+VB+VA && slot_of(p) < 2*HA;
    endfunction

    function automatic int m_addr(input int p);
        return (line_of(p) - (VS+VB))*HA + slot_of(p)/2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every cycle against the frame-position model
    always @(negedge PCLK) begin
        if (chk_on) begin
            bit          e_rd, e_href, e_vs, e_hs, e_fs;
            logic [15:0] word;
            logic [7:0]  e_d;
            int          p;
            e_rd = m_active(pos_m) && (slot_of(pos_m) % 2 == 0);
            chk("rd_en", 32'(RD_EN), 32'(e_rd));
            if (e_rd) chk("rd_addr", 32'(RD_ADDR), 32'(m_addr(pos_m)));
            p      = h1_m;
            e_href = m_active(p);
            e_vs   = (p >= 0) && (line_of(p) < VS);
            e_hs   = (p >= 0) && (slot_of(p) >= 2*HA) && (slot_of(p) < 2*(HA+HS));
            e_fs   = (p == 0);
            e_d    = 8'h00;
            if (e_href) begin
                word = 16'(m_addr(p)) + 16'hA500;
                e_d  = (slot_of(p) % 2 == 0) ? word[15:8] : word[7:0];
            end
            chk("href", 32'(HREF), 32'(e_href));
            chk("vsync", 32'(VSYNC), 32'(e_vs));
            chk("hsync", 32'(HSYNC), 32'(e_hs));
            chk("frame_start", 32'(FRAME_START), 32'(e_fs));
            chk("d", 32'(D), 32'(e_d));
        end
    end

    // Driver tasks
    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        while (FRAME_START !== 1'b1 && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (FRAME_START !== 1'b1) chk("frame_start_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_sig_href(input int budget);
        int n;
        n = 0;
        while (HREF !== 1'b1 && n < budget) begin
            @(negedge PCLK);
            n++;
        end
        if (HREF !== 1'b1) chk("href_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int vs_c, hs_c, href_c, burst_c, fs_c, rd_c, n;
        bit prev_href;

        RST = 1'b1;
        EN  = 1'b0;
        @(posedge PCLK); #1;
        chk_on = 1'b1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_d", 32'(D), 32'(0));
        chk("rst_href", 32'(HREF), 32'(0));
        chk("rst_vsync", 32'(VSYNC), 32'(0));
        chk("rst_hsync", 32'(HSYNC), 32'(0));
        chk("rst_fs", 32'(FRAME_START), 32'(0));
        chk("rst_rd_en", 32'(RD_EN), 32'(0));
        chk("rst_rd_addr", 32'(RD_ADDR), 32'(0));

        @(posedge PCLK); #1;
        RST = 1'b0;
        EN  = 1'b1;

        // One full frame starting at the first FRAME_START
        exp_q = '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'hA5, 8'h02, 8'hA5, 8'h03};
        @(negedge PCLK);
        wait_fs(200);
        vs_c = 0; hs_c = 0; href_c = 0; burst_c = 0; fs_c = 0; rd_c = 0;
        prev_href = 1'b0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k > 0) @(negedge PCLK);
            vs_c   += int'(VSYNC);
            hs_c   += int'(HSYNC);
            href_c += int'(HREF);
            fs_c   += int'(FRAME_START);
            if (HREF && !prev_href) burst_c++;
            prev_href = HREF;
            if (RD_EN) begin
                chk("addr_seq", 32'(RD_ADDR), 32'(rd_c));
                rd_c++;
            end
            if (HREF && exp_q.size() > 0) chk("line0_byte", 32'(D), 32'(exp_q.pop_front()));
        end
        chk("frame_rd_en", 32'(rd_c), 32'(12));
        chk("frame_vsync", 32'(vs_c), 32'(12));
        chk("frame_href", 32'(href_c), 32'(24));
        chk("frame_bursts", 32'(burst_c), 32'(3));
        chk("frame_hsync", 32'(hs_c), 32'(12));
        chk("frame_fs", 32'(fs_c), 32'(1));
        chk("line0_bytes_left", 32'(exp_q.size()), 32'(0));
        @(negedge PCLK);
        chk("fs_period", 32'(FRAME_START), 32'(1));

        // Drop EN early in the second frame: it must still complete, then go quiet
        @(posedge PCLK); #1;
        EN = 1'b0;
        href_c = 0; fs_c = 0; rd_c = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge PCLK);
            href_c += int'(HREF);
            fs_c   += int'(FRAME_START);
            rd_c   += int'(RD_EN);
        end
        chk("drain_href", 32'(href_c), 32'(24));
        chk("drain_rd_en", 32'(rd_c), 32'(12));
        chk("drain_fs", 32'(fs_c), 32'(0));
        chk("drain_idle", 32'(dbg_run), 32'(0));

        // Re-enable: FRAME_START appears on the fourth negedge after EN is raised
        @(posedge PCLK); #1;
        EN = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge PCLK);
            n++;
            if (FRAME_START === 1'b1) break;
        end
        chk("fs_latency", 32'(n), 32'(4));

        // Reset in the middle of an active byte
        wait_sig_href(200);
        RST = 1'b1;
        @(negedge PCLK);
        chk("rst_mid_d", 32'(D), 32'(0));
        chk("rst_mid_href", 32'(HREF), 32'(0));
        chk("rst_mid_rd_en", 32'(RD_EN), 32'(0));
        @(posedge PCLK); #1;
        RST = 1'b0;
        n = 0;
        while (RD_EN !== 1'b1 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        chk("addr_restart_seen", 32'(RD_EN), 32'(1));
        chk("addr_restart", 32'(RD_ADDR), 32'(0));

        repeat (20) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
